// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// Default widths, the NOP control encoding, the per-edge update selector
// and a saturating increment used by the optional performance counters.
package id_exe_pipe_reg_pkg;

    localparam int DEF_XLEN           = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CTRL_WIDTH     = 16;

    // All-zero control bundle: EX/MEM/WB take no action on it.
    localparam logic [DEF_CTRL_WIDTH-1:0] CTRL_NOP = '0;

    // What the register does at the next clock edge, highest priority first.
    typedef enum logic [2:0] {
        UPD_FLUSH,   // branch redirect kills the entry and the ID instruction
        UPD_BUBBLE,  // load-use hazard: insert one empty slot
        UPD_LOAD,    // accept the ID payload
        UPD_DRAIN,   // EX consumed the entry and ID has nothing to give
        UPD_HOLD     // EX is stalled: keep the entry, snoop WB writes
    } upd_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/id_exe_pipe_reg_if.sv
// ID-side, WB-snoop and EX-side signals of the ID/EX pipeline register.
// slave: the register's view; master: the surrounding pipeline's view.
interface id_exe_pipe_reg_if
    import id_exe_pipe_reg_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
);
    // ID side
    logic                      id_valid;
    logic                      id_ready;
    logic [XLEN-1:0]           id_pc;
    logic [31:0]               id_inst;
    logic [XLEN-1:0]           id_rs1_data;
    logic [XLEN-1:0]           id_rs2_data;
    logic [XLEN-1:0]           id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_reg_raddr1;
    logic [REG_ADDR_WIDTH-1:0] id_reg_raddr2;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic [REG_ADDR_WIDTH-1:0] id_reg_waddr;
    logic                      id_reg_wen;
    logic                      id_mem_ren;
    logic [CTRL_WIDTH-1:0]     id_ctrl;
    // Redirect and WB snoop
    logic                      flush;
    logic                      wb_reg_wen;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr;
    logic [XLEN-1:0]           wb_reg_wdata;
    // EX side
    logic                      ex_ready;
    logic                      id_exe_valid;
    logic [XLEN-1:0]           id_exe_pc;
    logic [31:0]               id_exe_inst;
    logic [XLEN-1:0]           id_exe_rs1_data;
    logic [XLEN-1:0]           id_exe_rs2_data;
    logic [XLEN-1:0]           id_exe_imm;
    logic [REG_ADDR_WIDTH-1:0] id_exe_reg_raddr1;
    logic [REG_ADDR_WIDTH-1:0] id_exe_reg_raddr2;
    logic [REG_ADDR_WIDTH-1:0] id_exe_reg_waddr;
    logic                      id_exe_reg_wen;
    logic                      id_exe_mem_ren;
    logic [CTRL_WIDTH-1:0]     id_exe_ctrl;
    logic                      load_use_stall;

    modport slave (
        input  id_valid, id_pc, id_inst, id_rs1_data, id_rs2_data, id_imm,
               id_reg_raddr1, id_reg_raddr2, id_rs1_used, id_rs2_used,
               id_reg_waddr, id_reg_wen, id_mem_ren, id_ctrl,
               flush, wb_reg_wen, wb_reg_waddr, wb_reg_wdata, ex_ready,
        output id_ready, id_exe_valid, id_exe_pc, id_exe_inst, id_exe_rs1_data,
               id_exe_rs2_data, id_exe_imm, id_exe_reg_raddr1, id_exe_reg_raddr2,
               id_exe_reg_waddr, id_exe_reg_wen, id_exe_mem_ren, id_exe_ctrl,
               load_use_stall
    );

    modport master (
        output id_valid, id_pc, id_inst, id_rs1_data, id_rs2_data, id_imm,
               id_reg_raddr1, id_reg_raddr2, id_rs1_used, id_rs2_used,
               id_reg_waddr, id_reg_wen, id_mem_ren, id_ctrl,
               flush, wb_reg_wen, wb_reg_waddr, wb_reg_wdata, ex_ready,
        input  id_ready, id_exe_valid, id_exe_pc, id_exe_inst, id_exe_rs1_data,
               id_exe_rs2_data, id_exe_imm, id_exe_reg_raddr1, id_exe_reg_raddr2,
               id_exe_reg_waddr, id_exe_reg_wen, id_exe_mem_ren, id_exe_ctrl,
               load_use_stall
    );

endinterface

// File: rtl/id_exe_pipe_reg_load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently held in ID/EX will only produce after MEM.
module load_use_detect
    import id_exe_pipe_reg_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      id_valid,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    input  logic                      exe_valid,
    input  logic                      exe_mem_ren,
    input  logic [REG_ADDR_WIDTH-1:0] exe_waddr,
    output logic                      hazard
);
    logic rs1_hit;
    logic rs2_hit;

    // Only sources the instruction really reads count; x0 never hazards.
    assign rs1_hit = rs1_used && (raddr1 == exe_waddr);
    assign rs2_hit = rs2_used && (raddr2 == exe_waddr);
    assign hazard  = id_valid && exe_valid && exe_mem_ren &&
                     (exe_waddr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, one-bubble load-use
// stall, branch flush and WB snooping of held operands.
// Optional feature: define ID_EXE_PERF_CNT_EN to add the saturating
// perf_bubble_cnt / perf_flush_cnt outputs.
module id_exe_pipe_reg
    import id_exe_pipe_reg_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    id_exe_pipe_reg_if.slave bus
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_bubble_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);
    logic                      exe_valid;
    logic [XLEN-1:0]           exe_pc;
    logic [31:0]               exe_inst;
    logic [XLEN-1:0]           exe_rs1_data;
    logic [XLEN-1:0]           exe_rs2_data;
    logic [XLEN-1:0]           exe_imm;
    logic [REG_ADDR_WIDTH-1:0] exe_raddr1;
    logic [REG_ADDR_WIDTH-1:0] exe_raddr2;
    logic [REG_ADDR_WIDTH-1:0] exe_waddr;
    logic                      exe_wen;
    logic                      exe_mem_ren;
    logic [CTRL_WIDTH-1:0]     exe_ctrl;

    logic advance;
    logic hazard;
    logic snoop1;
    logic snoop2;
    upd_e upd;

    load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_load_use_detect (
        .id_valid    (bus.id_valid),
        .rs1_used    (bus.id_rs1_used),
        .rs2_used    (bus.id_rs2_used),
        .raddr1      (bus.id_reg_raddr1),
        .raddr2      (bus.id_reg_raddr2),
        .exe_valid   (exe_valid),
        .exe_mem_ren (exe_mem_ren),
        .exe_waddr   (exe_waddr),
        .hazard      (hazard)
    );

    assign advance            = !exe_valid || bus.ex_ready;
    assign bus.load_use_stall = hazard && advance && !bus.flush;
    assign bus.id_ready       = bus.flush || (advance && !hazard);

    // A WB write to a held source refreshes it; x0 is constant and never snooped.
    assign snoop1 = bus.wb_reg_wen && (bus.wb_reg_waddr != '0) &&
                    (bus.wb_reg_waddr == exe_raddr1);
    assign snoop2 = bus.wb_reg_wen && (bus.wb_reg_waddr != '0) &&
                    (bus.wb_reg_waddr == exe_raddr2);

    // Select the single highest-priority update for the coming edge.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
        upd = UPD_HOLD;
        if (bus.flush)              upd = UPD_FLUSH;
        else if (advance && hazard) upd = UPD_BUBBLE;
        else if (advance && bus.id_valid) upd = UPD_LOAD;
        else if (advance)           upd = UPD_DRAIN;
    end

    // Valid and the side-effecting control fields; cleared whenever the entry dies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            exe_valid   <= 1'b0;
            exe_wen     <= 1'b0;
            exe_mem_ren <= 1'b0;
            exe_ctrl    <= CTRL_WIDTH'(CTRL_NOP);
        end else begin
            case (upd)
                UPD_LOAD: begin
                    exe_valid   <= 1'b1;
                    exe_wen     <= bus.id_reg_wen;
                    exe_mem_ren <= bus.id_mem_ren;
                    exe_ctrl    <= bus.id_ctrl;
                end
                UPD_HOLD: ;
                default: begin
                    exe_valid   <= 1'b0;
                    exe_wen     <= 1'b0;
                    exe_mem_ren <= 1'b0;
                    exe_ctrl    <= CTRL_WIDTH'(CTRL_NOP);
                end
            endcase
        end
    end

    // Data payload: captured on accept, refreshed by WB while EX stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload flops are reset too so the whole bus reads zero out of reset; there is no array here.
            exe_pc       <= '0;
            exe_inst     <= '0;
            exe_rs1_data <= '0;
            exe_rs2_data <= '0;
            exe_imm      <= '0;
            exe_raddr1   <= '0;
            exe_raddr2   <= '0;
            exe_waddr    <= '0;
        end else if (upd == UPD_LOAD) begin
            exe_pc       <= bus.id_pc;
            exe_inst     <= bus.id_inst;
            exe_rs1_data <= bus.id_rs1_data;
            exe_rs2_data <= bus.id_rs2_data;
            exe_imm      <= bus.id_imm;
            exe_raddr1   <= bus.id_reg_raddr1;
            exe_raddr2   <= bus.id_reg_raddr2;
            exe_waddr    <= bus.id_reg_waddr;
        end else if (upd == UPD_HOLD) begin
            if (snoop1) exe_rs1_data <= bus.wb_reg_wdata;
            if (snoop2) exe_rs2_data <= bus.wb_reg_wdata;
        end
    end

    assign bus.id_exe_valid      = exe_valid;
    assign bus.id_exe_pc         = exe_pc;
    assign bus.id_exe_inst       = exe_inst;
    assign bus.id_exe_rs1_data   = exe_rs1_data;
    assign bus.id_exe_rs2_data   = exe_rs2_data;
    assign bus.id_exe_imm        = exe_imm;
    assign bus.id_exe_reg_raddr1 = exe_raddr1;
    assign bus.id_exe_reg_raddr2 = exe_raddr2;
    assign bus.id_exe_reg_waddr  = exe_waddr;
    assign bus.id_exe_reg_wen    = exe_wen;
    assign bus.id_exe_mem_ren    = exe_mem_ren;
    assign bus.id_exe_ctrl       = exe_ctrl;

`ifdef ID_EXE_PERF_CNT_EN
    // Saturating counters of inserted bubbles and flushes that killed real work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (bus.load_use_stall)
                perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
            if (bus.flush && (exe_valid || bus.id_valid))
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_id_exe_pipe_reg;
    import id_exe_pipe_reg_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    id_exe_pipe_reg_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW), .CTRL_WIDTH(CW)) bus ();

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] m_bub;
    logic [31:0] m_fl;
`endif

    id_exe_pipe_reg #(.XLEN(XLEN), .REG_ADDR_WIDTH(RAW), .CTRL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ID_EXE_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    // Reference model: the instruction the EX stage currently sees.
    typedef struct {
        logic            valid;
        logic [31:0]     pc, inst, rs1, rs2, imm;
        logic [RAW-1:0]  ra1, ra2, wa;
        logic            wen, mren;
        logic [CW-1:0]   ctrl;
    } entry_t;

    entry_t m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 1'b0, pc: '0, inst: '0, rs1: '0, rs2: '0, imm: '0,
              ra1: '0, ra2: '0, wa: '0, wen: 1'b0, mren: 1'b0, ctrl: '0};
`ifdef ID_EXE_PERF_CNT_EN
        m_bub = '0;
        m_fl  = '0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/valid"}, bus.id_exe_valid, 0);
        check({tag, "/pc"},    bus.id_exe_pc, 0);
        check({tag, "/inst"},  bus.id_exe_inst, 0);
        check({tag, "/rs1"},   bus.id_exe_rs1_data, 0);
        check({tag, "/rs2"},   bus.id_exe_rs2_data, 0);
        check({tag, "/imm"},   bus.id_exe_imm, 0);
        check({tag, "/ra1"},   bus.id_exe_reg_raddr1, 0);
        check({tag, "/ra2"},   bus.id_exe_reg_raddr2, 0);
        check({tag, "/wa"},    bus.id_exe_reg_waddr, 0);
        check({tag, "/wen"},   bus.id_exe_reg_wen, 0);
        check({tag, "/mren"},  bus.id_exe_mem_ren, 0);
        check({tag, "/ctrl"},  bus.id_exe_ctrl, 0);
`ifdef ID_EXE_PERF_CNT_EN
        check({tag, "/pbub"},  perf_bubble_cnt, 0);
        check({tag, "/pfl"},   perf_flush_cnt, 0);
`endif
    endtask

    task automatic check_entry(input string tag);
        check({tag, "/valid"}, bus.id_exe_valid, m.valid);
        check({tag, "/wen"},   bus.id_exe_reg_wen, m.wen);
        check({tag, "/mren"},  bus.id_exe_mem_ren, m.mren);
        check({tag, "/ctrl"},  bus.id_exe_ctrl, m.ctrl);
        if (m.valid) begin
            check({tag, "/pc"},   bus.id_exe_pc, m.pc);
            check({tag, "/inst"}, bus.id_exe_inst, m.inst);
            check({tag, "/rs1"},  bus.id_exe_rs1_data, m.rs1);
            check({tag, "/rs2"},  bus.id_exe_rs2_data, m.rs2);
            check({tag, "/imm"},  bus.id_exe_imm, m.imm);
            check({tag, "/ra1"},  bus.id_exe_reg_raddr1, m.ra1);
            check({tag, "/ra2"},  bus.id_exe_reg_raddr2, m.ra2);
            check({tag, "/wa"},   bus.id_exe_reg_waddr, m.wa);
        end
`ifdef ID_EXE_PERF_CNT_EN
        check({tag, "/pbub"}, perf_bubble_cnt, m_bub);
        check({tag, "/pfl"},  perf_flush_cnt, m_fl);
`endif
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        logic src_hit, hz, adv, exp_stall, exp_ready;
        #1;
        adv = !m.valid || bus.ex_ready;
        src_hit = (bus.id_rs1_used && bus.id_reg_raddr1 == m.wa) ||
                  (bus.id_rs2_used && bus.id_reg_raddr2 == m.wa);
        hz = bus.id_valid && m.valid && m.mren && m.wa != 0 && src_hit;
        exp_stall = hz && adv && !bus.flush;
        exp_ready = bus.flush || (adv && !hz);
        check({tag, "/id_ready"}, bus.id_ready, exp_ready);
        check({tag, "/stall"},    bus.load_use_stall, exp_stall);
`ifdef ID_EXE_PERF_CNT_EN
        if (exp_stall) m_bub = m_bub + 1;
        if (bus.flush && (m.valid || bus.id_valid)) m_fl = m_fl + 1;
`endif
        if (bus.flush || (adv && hz) || (adv && !bus.id_valid)) begin
            m.valid = 1'b0; m.wen = 1'b0; m.mren = 1'b0; m.ctrl = '0;
        end else if (adv) begin
            m.valid = 1'b1;
            m.pc = bus.id_pc; m.inst = bus.id_inst; m.rs1 = bus.id_rs1_data;
            m.rs2 = bus.id_rs2_data; m.imm = bus.id_imm;
            m.ra1 = bus.id_reg_raddr1; m.ra2 = bus.id_reg_raddr2; m.wa = bus.id_reg_waddr;
            m.wen = bus.id_reg_wen; m.mren = bus.id_mem_ren; m.ctrl = bus.id_ctrl;
        end else if (bus.wb_reg_wen && bus.wb_reg_waddr != 0) begin
            if (bus.wb_reg_waddr == m.ra1) m.rs1 = bus.wb_reg_wdata;
            if (bus.wb_reg_waddr == m.ra2) m.rs2 = bus.wb_reg_wdata;
        end
        @(posedge clk);
        #1;
        check_entry(tag);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [RAW-1:0] ra1, input logic u1,
                          input logic [RAW-1:0] ra2, input logic u2,
                          input logic [RAW-1:0] wa, input logic wen, input logic mren);
        bus.id_valid      = v;
        bus.id_pc         = pc;
        bus.id_inst       = $urandom;
        bus.id_rs1_data   = $urandom;
        bus.id_rs2_data   = $urandom;
        bus.id_imm        = $urandom;
        bus.id_reg_raddr1 = ra1;
        bus.id_rs1_used   = u1;
        bus.id_reg_raddr2 = ra2;
        bus.id_rs2_used   = u2;
        bus.id_reg_waddr  = wa;
        bus.id_reg_wen    = wen;
        bus.id_mem_ren    = mren;
        bus.id_ctrl       = CW'($urandom_range(1, 16'hFFFF));
    endtask

    task automatic quiet_side();
        bus.flush        = 1'b0;
        bus.wb_reg_wen   = 1'b0;
        bus.wb_reg_waddr = '0;
        bus.wb_reg_wdata = '0;
        bus.ex_ready     = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        quiet_side();
        set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // First instruction: visible one cycle after acceptance.
        set_id(1'b1, 32'h8000_0000, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        #1 check("pre_edge/valid", bus.id_exe_valid, 0);
        check("pre_edge/pc", bus.id_exe_pc, 0);
        cycle("first");
        check("first/pc_const", bus.id_exe_pc, 32'h8000_0000);

        // Load-use: load x5 in EX, consumer reads x5 through rs1.
        set_id(1'b1, 32'h8000_0004, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle("lu_load");
        set_id(1'b1, 32'h8000_0008, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        #1 check("lu/stall_const", bus.load_use_stall, 1);
        check("lu/ready_const", bus.id_ready, 0);
        cycle("lu_bubble");
        check("lu/bubble_valid", bus.id_exe_valid, 0);
        check("lu/bubble_ctrl", bus.id_exe_ctrl, 0);
        cycle("lu_accept");
        check("lu/accept_pc", bus.id_exe_pc, 32'h8000_0008);

        // rs1 field names x5 but is not read: no stall.
        set_id(1'b1, 32'h8000_000C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle("unused_load");
        set_id(1'b1, 32'h8000_0010, 5'd5, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1);
        #1 check("unused/stall_const", bus.load_use_stall, 0);
        cycle("unused_accept");
        check("unused/accept_valid", bus.id_exe_valid, 1);

        // Entry is now a load to x0: reading x0 never stalls.
        set_id(1'b1, 32'h8000_0014, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        #1 check("x0/stall_const", bus.load_use_stall, 0);
        cycle("x0_accept");

        // Snoop: entry reads x0 and x7, EX stalls for four cycles.
        set_id(1'b1, 32'h8000_0018, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        cycle("snoop_load");
        set_id(1'b1, 32'h8000_001C, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        cycle("snoop_h1");
        bus.wb_reg_wen = 1'b1; bus.wb_reg_waddr = 5'd7; bus.wb_reg_wdata = 32'hDEAD_BEEF;
        cycle("snoop_h2");
        check("snoop/rs2_const", bus.id_exe_rs2_data, 32'hDEAD_BEEF);
        bus.wb_reg_waddr = 5'd0; bus.wb_reg_wdata = 32'h1234_5678;
        cycle("snoop_h3");
        check("snoop/x0_rs2_const", bus.id_exe_rs2_data, 32'hDEAD_BEEF);
        bus.wb_reg_wen = 1'b0;
        #1 check("snoop/ready_const", bus.id_ready, 0);
        cycle("snoop_h4");
        quiet_side();

        // Flush together with a load-use hazard: flush wins.
        set_id(1'b1, 32'h8000_0020, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cycle("flush_load");
        set_id(1'b1, 32'h8000_0024, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1 check("flush/ready_const", bus.id_ready, 1);
        check("flush/stall_const", bus.load_use_stall, 0);
        cycle("flush");
        check("flush/valid_const", bus.id_exe_valid, 0);
        quiet_side();

        // Hold under EX stall, then asynchronous reset mid-hold.
        set_id(1'b1, 32'h8000_0028, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        cycle("hold_load");
        set_id(1'b1, 32'h8000_002C, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        cycle("hold1");
        cycle("hold2");
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet_side();

        // Randomized traffic on a small register space to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom,
                   RAW'($urandom_range(0, 3)), 1'($urandom),
                   RAW'($urandom_range(0, 3)), 1'($urandom),
                   RAW'($urandom_range(0, 3)), 1'($urandom),
                   $urandom_range(0, 2) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            bus.ex_ready     = ($urandom_range(0, 3) != 0);
            bus.wb_reg_wen   = 1'($urandom);
            bus.wb_reg_waddr = RAW'($urandom_range(0, 3));
            bus.wb_reg_wdata = $urandom;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
